sc_lives_manager: RTL and testbench

//  Parametrised lives manager for the Frogger game datapath. It loads a starting life count and

---
 rtl/sc_lives_manager_if.sv | 47 ++++
 rtl/sc_lives_manager.sv | 131 +++++++++++++
 tb/tb_sc_lives_manager.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sc_lives_manager_if.sv
// -----------------------------------------------------------------------------
// sc_lives_manager_if
//   Bundle of the lives-manager request inputs and status outputs.
//   Signal names follow the original lives-manager port names.
//   Modports:
//     master : drives start/hit/bonus (active-low levels), observes status
//     slave  : the lives manager itself
//   Signals:
//     SC_LIVES_MANAGER_start_InLow       start/restart request (active low)
//     SC_LIVES_MANAGER_hit_InLow         collision indication (active low)
//     SC_LIVES_MANAGER_bonus_InLow       bonus-life request (active low)
//     SC_LIVES_MANAGER_lives_Out         current lives count
//     SC_LIVES_MANAGER_gameover_OutHigh  high while in GAME_OVER
//     SC_LIVES_MANAGER_invuln_OutHigh    high while in INVULN
//     SC_LIVES_MANAGER_lostlife_OutHigh  one-cycle pulse per life removed
// -----------------------------------------------------------------------------
interface sc_lives_manager_if #(
  parameter int LIVES_DATAWIDTH = 3
);
  logic                       SC_LIVES_MANAGER_start_InLow;
  logic                       SC_LIVES_MANAGER_hit_InLow;
  logic                       SC_LIVES_MANAGER_bonus_InLow;
  logic [LIVES_DATAWIDTH-1:0] SC_LIVES_MANAGER_lives_Out;
  logic                       SC_LIVES_MANAGER_gameover_OutHigh;
  logic                       SC_LIVES_MANAGER_invuln_OutHigh;
  logic                       SC_LIVES_MANAGER_lostlife_OutHigh;

  modport master (
    output SC_LIVES_MANAGER_start_InLow,
    output SC_LIVES_MANAGER_hit_InLow,
    output SC_LIVES_MANAGER_bonus_InLow,
    input  SC_LIVES_MANAGER_lives_Out,
    input  SC_LIVES_MANAGER_gameover_OutHigh,
    input  SC_LIVES_MANAGER_invuln_OutHigh,
    input  SC_LIVES_MANAGER_lostlife_OutHigh
  );

  modport slave (
    input  SC_LIVES_MANAGER_start_InLow,
    input  SC_LIVES_MANAGER_hit_InLow,
    input  SC_LIVES_MANAGER_bonus_InLow,
    output SC_LIVES_MANAGER_lives_Out,
    output SC_LIVES_MANAGER_gameover_OutHigh,
    output SC_LIVES_MANAGER_invuln_OutHigh,
    output SC_LIVES_MANAGER_lostlife_OutHigh
  );
endinterface

// File: rtl/sc_lives_manager.sv
// -----------------------------------------------------------------------------
// sc_lives_manager
//   Lives manager for the Frogger datapath: loads a starting life count on
//   start, removes one life per hit with a post-hit invulnerability window,
//   flags game over at zero lives and optionally awards bonus lives up to a cap.
//   Optional feature macro: SC_LIVES_MANAGER_BONUS_EN (bonus lives enabled).
//   Ports:
//     SC_LIVES_MANAGER_CLOCK_50      system clock, rising edge
//     SC_LIVES_MANAGER_RESET_InHigh  asynchronous active-high reset
//     bus (slave)                    start/hit/bonus requests, lives/status out
//   Parameters:
//     LIVES_DATAWIDTH, INIT_LIVES, MAX_LIVES, INVULN_CYCLES
// -----------------------------------------------------------------------------
module sc_lives_manager #(
  parameter int LIVES_DATAWIDTH = 3,
  parameter int INIT_LIVES      = 3,
  parameter int MAX_LIVES       = 7,
  parameter int INVULN_CYCLES   = 50000000
) (
  input  logic               SC_LIVES_MANAGER_CLOCK_50,
  input  logic               SC_LIVES_MANAGER_RESET_InHigh,
  sc_lives_manager_if.slave  bus
);

  localparam int CW = $clog2(INVULN_CYCLES + 1);
  localparam logic [LIVES_DATAWIDTH-1:0] LV_INIT = LIVES_DATAWIDTH'(INIT_LIVES);
  localparam logic [LIVES_DATAWIDTH-1:0] LV_MAX  = LIVES_DATAWIDTH'(MAX_LIVES);
  localparam logic [CW-1:0]              CD_LOAD = CW'(INVULN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ALIVE, INVULN, GAME_OVER} state_t;

  state_t                     r_state, w_state_nx;
  logic [LIVES_DATAWIDTH-1:0] r_lives, w_lives_nx, w_lives_inc;
  logic [CW-1:0]              r_cool, w_cool_nx;
  logic                       r_lostlife, w_lost_nx;
  logic                       r_start_prev, r_hit_prev;
  logic                       w_start_ev, w_hit_ev, w_bonus_ev;

  assign w_start_ev = r_start_prev & ~bus.SC_LIVES_MANAGER_start_InLow;
  assign w_hit_ev   = r_hit_prev   & ~bus.SC_LIVES_MANAGER_hit_InLow;

`ifdef SC_LIVES_MANAGER_BONUS_EN
  logic r_bonus_prev;
  always_ff @(posedge SC_LIVES_MANAGER_CLOCK_50 or posedge SC_LIVES_MANAGER_RESET_InHigh) begin
    if (SC_LIVES_MANAGER_RESET_InHigh) r_bonus_prev <= 1'b1;
    else                               r_bonus_prev <= bus.SC_LIVES_MANAGER_bonus_InLow;
  end
  assign w_bonus_ev = r_bonus_prev & ~bus.SC_LIVES_MANAGER_bonus_InLow;
`else
  assign w_bonus_ev = 1'b0;
`endif

  assign w_lives_inc = (r_lives >= LV_MAX) ? LV_MAX : r_lives + 1'b1;

  always_ff @(posedge SC_LIVES_MANAGER_CLOCK_50 or posedge SC_LIVES_MANAGER_RESET_InHigh) begin
    if (SC_LIVES_MANAGER_RESET_InHigh) begin
      r_state      <= IDLE;
      r_lives      <= '0;
      r_cool       <= '0;
      r_lostlife   <= 1'b0;
      r_start_prev <= 1'b1;
      r_hit_prev   <= 1'b1;
    end else begin
      r_state      <= w_state_nx;
      r_lives      <= w_lives_nx;
      r_cool       <= w_cool_nx;
      r_lostlife   <= w_lost_nx;
      r_start_prev <= bus.SC_LIVES_MANAGER_start_InLow;
      r_hit_prev   <= bus.SC_LIVES_MANAGER_hit_InLow;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_lives_nx = r_lives;
    w_cool_nx  = r_cool;
    w_lost_nx  = 1'b0;
    case (r_state)
      IDLE, GAME_OVER: begin
        w_lives_nx = '0;
        if (w_start_ev) begin
          w_lives_nx = LV_INIT;
          w_state_nx = ALIVE;
        end
      end
      ALIVE: begin
        if (w_start_ev) begin
          w_lives_nx = LV_INIT;
          w_cool_nx  = '0;
        end else if (w_hit_ev && w_bonus_ev) begin
          // Hit and bonus cancel on the count, but the hit still costs a
          // pulse and opens the invulnerability window.
          w_lost_nx  = 1'b1;
          w_cool_nx  = CD_LOAD;
          w_state_nx = INVULN;
        end else if (w_hit_ev) begin
          w_lost_nx = 1'b1;
          if (r_lives > 1) begin
            w_lives_nx = r_lives - 1'b1;
            w_cool_nx  = CD_LOAD;
            w_state_nx = INVULN;
          end else begin
            w_lives_nx = '0;
            w_state_nx = GAME_OVER;
          end
        end else if (w_bonus_ev) begin
          w_lives_nx = w_lives_inc;
        end
      end
      INVULN: begin
        if (w_start_ev) begin
          w_lives_nx = LV_INIT;
          w_cool_nx  = '0;
          w_state_nx = ALIVE;
        end else begin
          if (w_bonus_ev) w_lives_nx = w_lives_inc;
          // Window spans the load value down to 0 inclusive.
          if (r_cool == '0) w_state_nx = ALIVE;
          else              w_cool_nx  = r_cool - 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.SC_LIVES_MANAGER_lives_Out        = r_lives;
  assign bus.SC_LIVES_MANAGER_gameover_OutHigh = (r_state == GAME_OVER);
  assign bus.SC_LIVES_MANAGER_invuln_OutHigh   = (r_state == INVULN);
  assign bus.SC_LIVES_MANAGER_lostlife_OutHigh = r_lostlife;

endmodule

// File: tb/tb_sc_lives_manager.sv
// -----------------------------------------------------------------------------
// tb_sc_lives_manager
//   Directed bench for sc_lives_manager with INIT_LIVES=3, MAX_LIVES=7,
//   INVULN_CYCLES=4. Bonus expectations follow SC_LIVES_MANAGER_BONUS_EN.
// -----------------------------------------------------------------------------
module tb_sc_lives_manager;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  sc_lives_manager_if #(.LIVES_DATAWIDTH(3)) bus ();

  sc_lives_manager #(
    .LIVES_DATAWIDTH(3),
    .INIT_LIVES     (3),
    .MAX_LIVES      (7),
    .INVULN_CYCLES  (4)
  ) dut (
    .SC_LIVES_MANAGER_CLOCK_50    (clk),
    .SC_LIVES_MANAGER_RESET_InHigh(rst),
    .bus                          (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input int lv, input int go, input int inv, input int lost);
    chk({tag, ".lives"},    int'(bus.SC_LIVES_MANAGER_lives_Out),        lv);
    chk({tag, ".gameover"}, int'(bus.SC_LIVES_MANAGER_gameover_OutHigh), go);
    chk({tag, ".invuln"},   int'(bus.SC_LIVES_MANAGER_invuln_OutHigh),   inv);
    chk({tag, ".lostlife"}, int'(bus.SC_LIVES_MANAGER_lostlife_OutHigh), lost);
  endtask

  int inv_cnt, lost_cnt;
`ifdef SC_LIVES_MANAGER_BONUS_EN
  int bon_exp[5] = '{4, 5, 6, 7, 7};
`else
  int bon_exp[5] = '{3, 3, 3, 3, 3};
`endif

  initial begin
    bus.SC_LIVES_MANAGER_start_InLow = 1'b1;
    bus.SC_LIVES_MANAGER_hit_InLow   = 1'b1;
    bus.SC_LIVES_MANAGER_bonus_InLow = 1'b1;
    #12;
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // hit while IDLE is ignored
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b0; tick();
    chk_all("idle_hit", 0, 0, 0, 0);
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b1; tick();

    // start
    bus.SC_LIVES_MANAGER_start_InLow = 1'b0; tick();
    chk_all("start", 3, 0, 0, 0);
    bus.SC_LIVES_MANAGER_start_InLow = 1'b1; tick();

    // hit held low 10 cycles: one life, one pulse, 4 invuln cycles
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b0;
    inv_cnt = 0; lost_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      inv_cnt  += int'(bus.SC_LIVES_MANAGER_invuln_OutHigh);
      lost_cnt += int'(bus.SC_LIVES_MANAGER_lostlife_OutHigh);
    end
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b1; tick();
    chk("held_hit.invuln_cycles", inv_cnt, 4);
    chk("held_hit.pulses", lost_cnt, 1);
    chk_all("held_hit.end", 2, 0, 0, 0);

    // second hit, then a hit inside the window is ignored
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b0; tick();
    chk_all("hit2", 1, 0, 1, 1);
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b1; tick();
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b0; tick();
    chk_all("hit_in_window", 1, 0, 1, 0);
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b1; tick(6);
    chk_all("window_over", 1, 0, 0, 0);

    // fatal hit, then hits in GAME_OVER produce nothing
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b0; tick();
    chk_all("hit3", 0, 1, 0, 1);
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b1; tick();
    chk_all("gameover_hold", 0, 1, 0, 0);
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b0; tick();
    chk_all("gameover_hit", 0, 1, 0, 0);
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b1; tick();

    // restart from GAME_OVER
    bus.SC_LIVES_MANAGER_start_InLow = 1'b0; tick();
    chk_all("restart_go", 3, 0, 0, 0);
    bus.SC_LIVES_MANAGER_start_InLow = 1'b1; tick();

    // five bonus events
    for (int i = 0; i < 5; i++) begin
      bus.SC_LIVES_MANAGER_bonus_InLow = 1'b0; tick();
      chk_all($sformatf("bonus%0d", i), bon_exp[i], 0, 0, 0);
      bus.SC_LIVES_MANAGER_bonus_InLow = 1'b1; tick();
    end

    // hit+bonus together at the current count
    bus.SC_LIVES_MANAGER_hit_InLow   = 1'b0;
    bus.SC_LIVES_MANAGER_bonus_InLow = 1'b0; tick();
`ifdef SC_LIVES_MANAGER_BONUS_EN
    chk_all("hit_bonus_max", 7, 0, 1, 1);
`else
    chk_all("hit_bonus_max", 2, 0, 1, 1);
`endif
    bus.SC_LIVES_MANAGER_hit_InLow   = 1'b1;
    bus.SC_LIVES_MANAGER_bonus_InLow = 1'b1; tick(6);

    // restart, bring lives down to 1, then hit+bonus
    bus.SC_LIVES_MANAGER_start_InLow = 1'b0; tick();
    chk_all("restart_alive", 3, 0, 0, 0);
    bus.SC_LIVES_MANAGER_start_InLow = 1'b1; tick();
    for (int i = 0; i < 2; i++) begin
      bus.SC_LIVES_MANAGER_hit_InLow = 1'b0; tick();
      bus.SC_LIVES_MANAGER_hit_InLow = 1'b1; tick(6);
    end
    chk_all("at_one", 1, 0, 0, 0);
    bus.SC_LIVES_MANAGER_hit_InLow   = 1'b0;
    bus.SC_LIVES_MANAGER_bonus_InLow = 1'b0; tick();
`ifdef SC_LIVES_MANAGER_BONUS_EN
    chk_all("hit_bonus_one", 1, 0, 1, 1);
`else
    chk_all("hit_bonus_one", 0, 1, 0, 1);
`endif
    bus.SC_LIVES_MANAGER_hit_InLow   = 1'b1;
    bus.SC_LIVES_MANAGER_bonus_InLow = 1'b1; tick(6);

    // start beats hit in the same cycle
    bus.SC_LIVES_MANAGER_start_InLow = 1'b0;
    bus.SC_LIVES_MANAGER_hit_InLow   = 1'b0; tick();
    chk_all("start_vs_hit", 3, 0, 0, 0);
    bus.SC_LIVES_MANAGER_start_InLow = 1'b1;
    bus.SC_LIVES_MANAGER_hit_InLow   = 1'b1; tick();

    // restart in the window clears cooldown; next hit acts at once
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b0; tick();
    chk_all("pre_restart_hit", 2, 0, 1, 1);
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b1;
    bus.SC_LIVES_MANAGER_start_InLow = 1'b0; tick();
    chk_all("restart_invuln", 3, 0, 0, 0);
    bus.SC_LIVES_MANAGER_start_InLow = 1'b1;
    bus.SC_LIVES_MANAGER_hit_InLow   = 1'b0; tick();
    chk_all("hit_after_restart", 2, 0, 1, 1);
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b1; tick();

    // async reset in the middle of the window
    @(negedge clk);
    rst = 1'b1; #1;
    chk_all("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_all("post_reset_idle", 0, 0, 0, 0);
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b0; tick();
    chk_all("post_reset_hit", 0, 0, 0, 0);
    bus.SC_LIVES_MANAGER_hit_InLow = 1'b1; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
